muldiv_ctl: RTL and testbench

//  Sequencer for the multi-cycle MULT/DIV resource and its HI/LO register pair.

---
 rtl/muldiv_ctl.sv | 84 ++++++++
 tb/tb_muldiv_ctl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/muldiv_ctl.sv
// muldiv_ctl: bit-serial MULT/DIV sequencer owning the HI/LO pair, with pipeline stall generation.
// Operands are reduced to magnitudes on accept; signs are reapplied in the FIX state.
module muldiv_ctl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Valid_EX,
  input  logic             Hold,
  input  logic [3:0]       AluControl_EX,
  input  logic [WIDTH-1:0] SrcA_EX,
  input  logic [WIDTH-1:0] SrcB_EX,
  output logic             MdStall,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_nxt;
  logic is_op, is_rd, accept, last;
  logic [CNT_W-1:0] cnt;
  logic is_div, neg_q, neg_r, b_zero;
  logic [WIDTH-1:0] rh, rl, mb, a_orig, dsh;
  logic [WIDTH:0] msum, ddiff;
  logic [2*WIDTH-1:0] prod;
  assign is_op  = Valid_EX & (AluControl_EX[3:1] == 3'b111);
  assign is_rd  = Valid_EX & (AluControl_EX[3:1] == 3'b101);
  assign accept = is_op & ~Busy & ~Hold;
  assign last   = cnt == CNT_W'(WIDTH-1);
  assign msum   = {1'b0, rh} + {1'b0, rl[0] ? mb : '0};
  // A partial remainder stays below the divisor (<= 2^(WIDTH-1)), so its top bit is always clear
  assign dsh    = {rh[WIDTH-2:0], rl[WIDTH-1]};
  assign ddiff  = {1'b0, dsh} - {1'b0, mb};
  assign prod   = {rh, rl};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = accept ? RUN : IDLE;
      RUN:     state_nxt = last ? FIX : RUN;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    Busy    = state != IDLE;
    MdStall = (is_op | is_rd) & Busy;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {Hi, Lo, rh, rl, mb, a_orig} <= '0;
      {cnt, is_div, neg_q, neg_r, b_zero, Done} <= '0;
    end else begin
      Done <= state == FIX;
      if (accept) begin
        rh     <= '0;
        rl     <= SrcA_EX[WIDTH-1] ? -SrcA_EX : SrcA_EX;
        mb     <= SrcB_EX[WIDTH-1] ? -SrcB_EX : SrcB_EX;
        a_orig <= SrcA_EX;
        cnt    <= '0;
        is_div <= AluControl_EX[0] == 1'b0;
        neg_q  <= SrcA_EX[WIDTH-1] ^ SrcB_EX[WIDTH-1];
        neg_r  <= SrcA_EX[WIDTH-1];
        b_zero <= SrcB_EX == '0;
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
        rh  <= is_div ? (ddiff[WIDTH] ? dsh : ddiff[WIDTH-1:0]) : msum[WIDTH:1];
        rl  <= is_div ? {rl[WIDTH-2:0], ~ddiff[WIDTH]} : {msum[0], rl[WIDTH-1:1]};
      end else if (state == FIX) begin
        if (!is_div) {Hi, Lo} <= neg_q ? -prod : prod;
        else if (b_zero) begin
          Hi <= a_orig;
          Lo <= '1;
        end else begin
          Hi <= neg_r ? -rh : rh;
          Lo <= neg_q ? -rl : rl;
        end
      end
    end
  end
endmodule

// File: tb/tb_muldiv_ctl.sv
// tb_muldiv_ctl: randomized and directed checks of muldiv_ctl against a plain-arithmetic model.
module tb_muldiv_ctl;
  localparam int W = 32;
  logic clk = 0, rst_n = 0, Valid_EX = 0, Hold = 0;
  logic [3:0] AluControl_EX = '0;
  logic [W-1:0] SrcA_EX = '0, SrcB_EX = '0;
  logic MdStall, Busy, Done;
  logic [W-1:0] Hi, Lo;
  int checks = 0, errors = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  muldiv_ctl dut (
    .clk(clk), .rst_n(rst_n), .Valid_EX(Valid_EX), .Hold(Hold),
    .AluControl_EX(AluControl_EX), .SrcA_EX(SrcA_EX), .SrcB_EX(SrcB_EX),
    .MdStall(MdStall), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  // {hi, lo} as the architecture defines them, from signed integer arithmetic
  function automatic logic [63:0] ref_result(logic [3:0] c, logic [31:0] a, logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    if (c == 4'b1111) return 64'(sa * sb);
    if (b == 0) return {a, 32'hFFFF_FFFF};
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($signed($urandom_range(0, 40)) - 20);
      default: return $urandom;
    endcase
  endfunction
  task automatic drive(int mode, bit busy_e);
    logic [3:0] c;
    c = 4'($urandom);
    Hold = 1'($urandom);
    Valid_EX = 1'($urandom);
    if (mode == 1) begin
      Valid_EX = 1;
      c = {3'b101, 1'($urandom)};
    end
    if (mode == 2) begin
      Valid_EX = 1;
      c = {3'b111, 1'($urandom)};
      SrcA_EX = $urandom;
      SrcB_EX = $urandom;
    end
    if (!busy_e && c[3:1] == 3'b111) Valid_EX = 0;
    AluControl_EX = c;
  endtask
  // Present an op (held off by Hold for hold_cyc cycles), then follow it edge by edge.
  task automatic run_op(logic [3:0] c, logic [31:0] a, logic [31:0] b, int hold_cyc, int mode, int abort_k = -1);
    logic [63:0] r;
    bit busy_e, rd_e;
    Valid_EX = 1; AluControl_EX = c; SrcA_EX = a; SrcB_EX = b; Hold = 1;
    repeat (hold_cyc) begin
      #1 chk("held_busy", Busy, 0);
      chk("held_stall", MdStall, 0);
      @(negedge clk);
    end
    Hold = 0;
    #1 chk("pre_busy", Busy, 0);
    @(negedge clk);
    r = ref_result(c, a, b);
    for (int k = 0; k <= 33; k++) begin
      busy_e = k <= 32;
      if (k == abort_k) begin
        rst_n = 0; Valid_EX = 1; AluControl_EX = 4'b1010;
        #1 chk("abort_busy", Busy, 0);
        chk("abort_done", Done, 0);
        chk("abort_stall", MdStall, 0);
        chk("abort_hi", Hi, 0);
        chk("abort_lo", Lo, 0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst_n = 1;
        return;
      end
      drive(mode, busy_e);
      rd_e = Valid_EX & (AluControl_EX[3:1] == 3'b111 || AluControl_EX[3:1] == 3'b101);
      #1 chk("busy", Busy, busy_e);
      chk("done", Done, k == 33);
      chk("stall", MdStall, rd_e & busy_e);
      chk("hi", Hi, busy_e ? m_hi : r[63:32]);
      chk("lo", Lo, busy_e ? m_lo : r[31:0]);
      if (k == 33) {m_hi, m_lo} = r;
      else @(negedge clk);
    end
  endtask
  initial begin
    Valid_EX = 1; AluControl_EX = 4'b1111; SrcA_EX = 7; SrcB_EX = 3;
    repeat (2) @(negedge clk);
    #1 chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_stall", MdStall, 0);
    chk("rst_hi", Hi, 0);
    chk("rst_lo", Lo, 0);
    @(negedge clk);
    rst_n = 1; Valid_EX = 0;
    @(negedge clk);
    run_op(4'b1111, 32'd7, 32'hFFFF_FFFD, 0, 0);
    run_op(4'b1110, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(4'b1110, 32'd7, 32'hFFFF_FFFE, 0, 0);
    run_op(4'b1110, 32'd5, 32'd0, 0, 0);
    run_op(4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(4'b1110, 32'hFFFF_FFF6, 32'd0, 0, 0);
    run_op(4'b1111, 32'h8000_0000, 32'h8000_0000, 0, 1);
    run_op(4'b1111, $urandom, $urandom, 0, 2);
    run_op(4'b1110, $urandom, 32'd13, 1, 0);
    run_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1, 10);
    run_op(4'b1111, 32'h0001_0003, 32'hFFFF_0005, 0, 1);
    repeat (30) run_op({3'b111, 1'($urandom)}, pick(), pick(), $urandom_range(0, 2), $urandom_range(0, 2));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
